cnu_msg_expand: RTL

Check-node message expander directly downstream of the check-node min-finder (CNU1). It takes the compressed check-node result (min1, min2, idx_min) plus the sign bits of the node's input messages. It then emits one check-to-variable message per edge, serially, over a valid/ready stream, using offset min-sum. The variable-node side consumes this stream.

---
 rtl/ldpc_pkg.sv | 19 +
 rtl/offset_sat.sv | 16 +
 rtl/cnu_msg_expand.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder constants and types.
// Used by the check-node message expander and its helpers.
package ldpc_pkg;

    localparam int BITS     = 8;
    localparam int DMAX     = 255;
    localparam int IDX_BITS = $clog2(DMAX);

    typedef logic signed [BITS-1:0] msg_t;
    typedef logic        [BITS-1:0] mag_t;
    typedef logic    [IDX_BITS-1:0] idx_t;
    typedef logic      [IDX_BITS:0] deg_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/offset_sat.sv
// Offset min-sum correction: subtract OFFSET from a magnitude,
// clamping at zero. Pure combinational.
module offset_sat
    import ldpc_pkg::*;
#(
    parameter int unsigned OFFSET = 1
) (
    input  logic [BITS-1:0] mag,
    output logic [BITS-1:0] mag_adj
);

    localparam mag_t OFF = mag_t'(OFFSET);

    assign mag_adj = (mag > OFF) ? mag - OFF : '0;

endmodule

// File: rtl/cnu_msg_expand.sv
// Expands a compressed check-node result (min1, min2, idx_min, signs)
// into one offset min-sum check-to-variable message per edge.
module cnu_msg_expand
    import ldpc_pkg::*;
#(
    parameter int unsigned OFFSET = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BITS-1:0]            min1,
    input  logic [BITS-1:0]            min2,
    input  logic [IDX_BITS-1:0]        idx_min,
    input  logic [DMAX-1:0]            signs,
    input  logic [IDX_BITS:0]          deg,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [BITS-1:0]     out_msg,
    output logic [IDX_BITS-1:0]        out_idx,
    output logic                       out_last
);

    state_t          state;
    idx_t            cnt;
    mag_t            min1_q;
    mag_t            min2_q;
    idx_t            idx_q;
    logic [DMAX-1:0] signs_q;
    deg_t            deg_q;
    logic            parity_q;

    logic            parity_in;
    logic            accept;

    mag_t            src_min1;
    mag_t            src_min2;
    idx_t            src_idx;
    logic [DMAX-1:0] src_signs;
    deg_t            src_deg;
    logic            src_parity;
    idx_t            e_next;

    mag_t            mag_sel;
    mag_t            mag_adj;
    logic            neg;
    msg_t            beat_msg;
    logic            beat_last;

    assign accept  = in_valid && in_ready;
    assign out_idx = cnt;

    // Overall sign parity over the node's active edges only.
    always_comb begin
        parity_in = 1'b0;
        for (int e = 0; e < DMAX; e++) begin
            if (e < int'(deg)) begin
                parity_in = parity_in ^ signs[e];
            end
        end
    end

    // First beat is built straight from the inputs so it appears one cycle
    // after accept; later beats come from the captured node.
    always_comb begin
        if (state == IDLE) begin
            src_min1   = min1;
            src_min2   = min2;
            src_idx    = idx_min;
            src_signs  = signs;
            src_deg    = deg;
            src_parity = parity_in;
            e_next     = '0;
        end else begin
            src_min1   = min1_q;
            src_min2   = min2_q;
            src_idx    = idx_q;
            src_signs  = signs_q;
            src_deg    = deg_q;
            src_parity = parity_q;
            e_next     = cnt + idx_t'(1);
        end
    end

    assign mag_sel = (e_next == src_idx) ? src_min2 : src_min1;

    offset_sat #(
        .OFFSET (OFFSET)
    ) u_offset_sat (
        .mag     (mag_sel),
        .mag_adj (mag_adj)
    );

    assign neg       = src_parity ^ src_signs[e_next];
    assign beat_msg  = neg ? msg_t'('0 - mag_adj) : msg_t'(mag_adj);
    assign beat_last = ({1'b0, e_next} == (src_deg - deg_t'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: capture registers are cleared too, so a reset mid-node leaves no stale edge data behind.
            state     <= IDLE;
            cnt       <= '0;
            min1_q    <= '0;
            min2_q    <= '0;
            idx_q     <= '0;
            signs_q   <= '0;
            deg_q     <= '0;
            parity_q  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_msg   <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        min1_q   <= min1;
                        min2_q   <= min2;
                        idx_q    <= idx_min;
                        signs_q  <= signs;
                        deg_q    <= deg;
                        parity_q <= parity_in;
                        if (deg != '0) begin
                            state     <= EMIT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_msg   <= beat_msg;
                            out_last  <= beat_last;
                            cnt       <= '0;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            cnt       <= '0;
                        end else begin
                            cnt      <= e_next;
                            out_msg  <= beat_msg;
                            out_last <= beat_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
